// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the core's load/store path: byte/half/word accesses
// on a word-organised array, with a fixed wait-state stall per access.
//
// state | meaning
// IDLE  | waiting for a request; rejects bad requests with access_err
// BUSY  | counting down the wait cycles on the latched request
// DONE  | load data already registered; store lanes written on exit
module data_mem_ctrl #(
    parameter int DEPTH_W = 10,
    parameter int WAIT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        access_err
);

    localparam int DEPTH = 1 << DEPTH_W;
    localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nxt;

    logic [3:0]         cnt;
    logic [DEPTH_W-1:0] idx_q;
    logic [1:0]         lane_q;
    logic [31:0]        wdata_q;
    logic [2:0]         f3_q;
    logic               wr_q;

    logic [31:0] mem [DEPTH];

    logic        req;
    logic        conflict;
    logic        f3_legal;
    logic        misaligned;
    logic        valid;
    logic [31:0] word_rd;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [3:0]  be;
    logic [31:0] wdata_lanes;

    // Address bits above the array index wrap silently.
    logic unused_addr;
    assign unused_addr = ^addr[31:DEPTH_W+2];

    // Request decode, only meaningful while IDLE
    always_comb begin
        req      = MemRead | MemWr;
        conflict = MemRead & MemWr;
        if (MemWr) begin
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        valid = req & ~conflict & f3_legal & ~misaligned;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        access_err = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    stall      = valid;
                    access_err = req & ~valid;
                end
                BUSY:    stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end

    // Request latch and wait-cycle down-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 4'd0;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            wdata_q <= 32'd0;
            f3_q    <= 3'b000;
            wr_q    <= 1'b0;
        end else begin
            if (state == IDLE && valid) begin
                cnt     <= CNT_INIT;
                idx_q   <= addr[DEPTH_W+1:2];
                lane_q  <= addr[1:0];
                wdata_q <= wdata;
                f3_q    <= funct3;
                wr_q    <= MemWr;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        word_rd  = mem[idx_q];
        byte_sel = word_rd[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? word_rd[31:16] : word_rd[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = word_rd;
        endcase
    end

    // Load data lands on the edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'd0;
        end else if (state == BUSY && cnt == 4'd0 && !wr_q) begin
            rdata <= load_ext;
        end
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                be          = 4'b0001 << lane_q;
                wdata_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be          = lane_q[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                be          = 4'b1111;
                wdata_lanes = wdata_q;
            end
        endcase
    end

    // Store commits on DONE exit; an async reset in DONE moves state to IDLE first,
    // so the pending store is dropped.
    always_ff @(posedge clk) begin
        if (state == DONE && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx_q][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: vector table on a WAIT=2 instance, plus
// reset-abort, dropped-request and back-to-back stall checks on WAIT=1/15 builds.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWr = 1'b0;
    logic [2:0]  funct3 = 3'b010;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        stall;
    logic        access_err;

    logic        rd_w1 = 1'b0;
    logic        rd_w15 = 1'b0;
    logic [31:0] rdata_w1, rdata_w15;
    logic        stall_w1, stall_w15, err_w1, err_w15;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_W(10), .WAIT(2)) u_dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWr(MemWr), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .access_err(access_err)
    );

    data_mem_ctrl #(.DEPTH_W(10), .WAIT(1)) u_w1 (
        .clk(clk), .rst(rst), .MemRead(rd_w1), .MemWr(1'b0), .funct3(3'b010),
        .addr(32'd0), .wdata(32'd0), .rdata(rdata_w1), .stall(stall_w1), .access_err(err_w1)
    );

    data_mem_ctrl #(.DEPTH_W(10), .WAIT(15)) u_w15 (
        .clk(clk), .rst(rst), .MemRead(rd_w15), .MemWr(1'b0), .funct3(3'b010),
        .addr(32'd0), .wdata(32'd0), .rdata(rdata_w15), .stall(stall_w15), .access_err(err_w15)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one request, hold it while stalled, drop it after the DONE cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic err, output int cycles, output logic [31:0] rd_out);
        @(posedge clk); #1;
        MemRead = rd; MemWr = wr; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        err = access_err;
        cycles = 0;
        while (stall && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        rd_out = rdata;
        @(posedge clk); #1;
        MemRead = 1'b0; MemWr = 1'b0;
    endtask

    function automatic logic sel_stall(input int which);
        return (which == 1) ? stall_w1 : stall_w15;
    endfunction

    task automatic b2b(input int which, input int w);
        int h1 = 0, l1 = 0, h2 = 0, guard = 0;
        @(posedge clk); #1;
        if (which == 1) rd_w1 = 1'b1; else rd_w15 = 1'b1;
        @(negedge clk);
        while (sel_stall(which) && guard < 100) begin h1++; guard++; @(negedge clk); end
        while (!sel_stall(which) && guard < 100) begin l1++; guard++; @(negedge clk); end
        while (sel_stall(which) && guard < 100) begin h2++; guard++; @(negedge clk); end
        @(posedge clk); #1;
        rd_w1 = 1'b0; rd_w15 = 1'b0;
        chk($sformatf("wait%0d first stall", w), h1, w + 1);
        chk($sformatf("wait%0d done gap", w), l1, 1);
        chk($sformatf("wait%0d second stall", w), h2, w + 1);
    endtask

    initial begin
        logic        err;
        int          cyc;
        logic [31:0] rv;

        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b0, 3'b010, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b1, 3'b010, 32'h10,   32'h00000000, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 1'b1, 3'b000, 32'h13,   32'h00000080, 1'b0, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b0, 3'b000, 32'h13,   32'h0,        1'b0, 32'hFFFFFF80};
        vecs[5]  = '{1'b1, 1'b0, 3'b100, 32'h13,   32'h0,        1'b0, 32'h00000080};
        vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h10,   32'h0,        1'b0, 32'h80000000};
        vecs[7]  = '{1'b1, 1'b0, 3'b001, 32'h11,   32'h0,        1'b1, 32'h80000000};
        vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h12,   32'h0,        1'b1, 32'h80000000};
        vecs[9]  = '{1'b1, 1'b1, 3'b010, 32'h10,   32'h0,        1'b1, 32'h80000000};
        vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h1004, 32'h12345678, 1'b0, 32'h80000000};
        vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h4,    32'h0,        1'b0, 32'h12345678};
        vecs[12] = '{1'b0, 1'b1, 3'b001, 32'h6,    32'hABCD8001, 1'b0, 32'h12345678};
        vecs[13] = '{1'b1, 1'b0, 3'b001, 32'h6,    32'h0,        1'b0, 32'hFFFF8001};
        vecs[14] = '{1'b1, 1'b0, 3'b101, 32'h6,    32'h0,        1'b0, 32'h00008001};
        vecs[15] = '{1'b1, 1'b0, 3'b000, 32'h5,    32'h0,        1'b0, 32'h00000056};
        vecs[16] = '{1'b1, 1'b0, 3'b010, 32'h4,    32'h0,        1'b0, 32'h80015678};
        vecs[17] = '{1'b1, 1'b0, 3'b011, 32'h4,    32'h0,        1'b1, 32'h80015678};
        vecs[18] = '{1'b0, 1'b1, 3'b100, 32'h4,    32'h0,        1'b1, 32'h80015678};
        vecs[19] = '{1'b1, 1'b0, 3'b010, 32'h2004, 32'h0,        1'b0, 32'h80015678};

        // Request presented while in reset must not stall or flag an error
        MemRead = 1'b1; MemWr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset stall", stall, 1'b0);
        chk("reset access_err", access_err, 1'b0);
        chk("reset rdata", rdata, 32'h0);
        MemRead = 1'b0; MemWr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            do_access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd, err, cyc, rv);
            chk($sformatf("v%0d access_err", i), err, vecs[i].exp_err);
            chk($sformatf("v%0d stall cycles", i), cyc, vecs[i].exp_err ? 0 : 3);
            chk($sformatf("v%0d rdata", i), rv, vecs[i].exp_rdata);
        end

        // Reset in BUSY drops the pending store and clears rdata
        do_access(1'b0, 1'b1, 3'b010, 32'h20, 32'h11111111, err, cyc, rv);
        MemWr = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'h22222222;
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy stall before rst", stall, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst mid stall", stall, 1'b0);
        chk("rst mid access_err", access_err, 1'b0);
        chk("rst mid rdata", rdata, 32'h0);
        @(posedge clk); #1;
        MemWr = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post rst stall", stall, 1'b0);
        do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, err, cyc, rv);
        chk("dropped store rdata", rv, 32'h11111111);
        chk("dropped store stall cycles", cyc, 3);

        // Request withdrawn in BUSY still completes on latched values
        @(posedge clk); #1;
        MemRead = 1'b1; funct3 = 3'b010; addr = 32'h4;
        @(posedge clk); #1;
        MemRead = 1'b0; addr = 32'h20;
        @(negedge clk);
        chk("withdrawn busy stall", stall, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        chk("withdrawn done stall", stall, 1'b0);
        chk("withdrawn rdata", rdata, 32'h80015678);

        b2b(1, 1);
        b2b(15, 15);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory responder for the RISC-V core's load/store path: accepts the decoder's MemRead/MemWr strobes with the ALU-computed byte address, performs byte/half/word accesses with sign/zero extension on a word-organised internal array, and stalls the core for a fixed number of wait cycles per access. Sits between the ALU result/Rd2 bus and the MemtoReg write-back mux.

## Interface
- DEPTH_W, 10: log2 of array depth in 32-bit words; DEPTH = 2^DEPTH_W
- WAIT, 2: wait cycles per access, legal range 1..15
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- MemRead  input  1  load request, held stable by core while stall=1
- MemWr  input  1  store request, held stable by core while stall=1
- funct3  input  3  access size/extension: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  32  byte address from ALU
- wdata  input  32  store data (Rd2); low byte/half used for SB/SH
- rdata  output  32  extended load data, registered
- stall  output  1  1 = core must hold PC and request
- access_err  output  1  1 = request rejected this cycle (misaligned/illegal/conflict)

## Operation
- Word index = addr[DEPTH_W+1:2]; addr bits above DEPTH_W+1 ignored (wrap-around, no error).
- Request = MemRead | MemWr. Conflict (both high) -> access_err, no access.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠00 -> access_err, no access.
- Illegal funct3: loads 011/110/111; stores anything other than 000/001/010 -> access_err.
- access_err is combinational, asserted only in IDLE; a rejected request never enters BUSY, never stalls, never writes, leaves rdata unchanged.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: valid request -> latch addr, wdata, funct3, direction; load cnt = WAIT-1; go BUSY.
  - BUSY: cnt≠0 -> decrement; cnt=0 -> go DONE.
  - DONE: load -> rdata updated at the DONE-entry edge; store -> byte lanes written at the DONE-exit edge. Unconditionally return to IDLE.
- stall = (IDLE & valid request) | BUSY; stall=0 in DONE so core advances on the DONE-exit edge.
- Store byte lanes: SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; SW writes all four.
- Load extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- Requests sampled in DONE are ignored (same instruction still presented); new request evaluated only in IDLE.

## Timing
- Reset values: state IDLE, cnt 0, rdata 0, stall 0, access_err 0; array contents undefined, not cleared.
- Valid request first seen in cycle N: stall=1 for cycles N..N+WAIT; DONE in cycle N+WAIT+1; rdata valid from cycle N+WAIT+1 until next load completes.
- Total stall cycles per access = WAIT+1; back-to-back accesses: next request seen in IDLE at N+WAIT+2.
- Store data visible to a load whose request starts any cycle after the store's DONE.
- rst asserted mid-access (BUSY or DONE): immediate IDLE, stall 0, pending store dropped (no lanes written), rdata 0.
- rst held high forces stall=0 and access_err=0 regardless of inputs.
- Request deasserted by the core while in BUSY (protocol violation): access still completes on latched values.

## Test plan
- SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 (WAIT=2) -> stall high 3 cycles each; rdata=0xDEADBEEF in DONE cycle.
- SB addr=0x13 wdata=0x80 over word 0x00000000, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80000000.
- LH addr=0x11 and LW addr=0x12 -> access_err=1 same cycle, stall=0, rdata unchanged; MemRead=MemWr=1 -> access_err=1.
- SW addr=(DEPTH*4)+0x4 wdata=0x12345678, LW addr=0x4 -> 0x12345678 (wrap).
- SW 0x20 wdata=0x11111111; start SW 0x20 wdata=0x22222222, assert rst in BUSY; after release LW 0x20 -> 0x11111111, rdata=0 immediately after reset.
- WAIT=1 and WAIT=15 builds: LW back-to-back -> stall exactly 2 / 16 cycles per access, one stall-free DONE cycle between.
